// File: rtl/bp_me_fill_serializer.sv
// rtl/bp_me_fill_serializer.sv - splits one block command into fill-width beats, critical word first
// Optional perf counters (msg_count_o, stall_count_o) under BP_ME_FILL_SERIALIZER_PERF_EN.
module bp_me_fill_serializer #(
  parameter int paddr_width_p = 34,
  parameter int fill_width_p  = 64,
  parameter int block_width_p = 512
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     in_v_i,
  output logic                     in_ready_o,
  input  logic                     in_write_i,
  input  logic [paddr_width_p-1:0] in_addr_i,
  input  logic [2:0]               in_size_i,
  input  logic [block_width_p-1:0] in_data_i,
  output logic                     out_v_o,
  input  logic                     out_ready_i,
  output logic                     out_write_o,
  output logic [paddr_width_p-1:0] out_addr_o,
  output logic [2:0]               out_size_o,
  output logic [fill_width_p-1:0]  out_data_o,
  output logic                     out_first_o,
  output logic                     out_last_o,
`ifdef BP_ME_FILL_SERIALIZER_PERF_EN
  output logic [31:0]              msg_count_o,
  output logic [31:0]              stall_count_o,
`endif
  output logic                     error_o
);

  localparam int beats_lp = block_width_p / fill_width_p;
  localparam int cnt_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int off_w_lp = $clog2(fill_width_p / 8);
  localparam logic [2:0] off_w_sz_lp = 3'(off_w_lp);
  localparam logic [2:0] max_size_lp = 3'($clog2(block_width_p / 8));

  localparam logic [0:0] idle_s = 1'b0;
  localparam logic [0:0] send_s = 1'b1;

  logic [0:0]               state_r;
  logic                     write_r;
  logic [paddr_width_p-1:0] addr_r;
  logic [2:0]               size_r;
  logic [block_width_p-1:0] data_r;
  logic [cnt_w_lp-1:0]      k_r;
  logic [cnt_w_lp-1:0]      last_idx_r;
  logic                     error_r;

  logic [2:0]               size_c;
  logic                     oversize;
  logic [cnt_w_lp-1:0]      last_idx_in;
  logic                     is_last;
  logic                     out_fire;
  logic                     accept;

  assign oversize = (in_size_i > max_size_lp);
  assign size_c   = oversize ? max_size_lp : in_size_i;

  // last_idx doubles as the wrap mask since the beat count is a power of two
  always_comb begin
    last_idx_in = '0;
    if (in_write_i && (size_c > off_w_sz_lp))
      last_idx_in = cnt_w_lp'((32'd1 << (size_c - off_w_sz_lp)) - 32'd1);
  end

  assign is_last    = (k_r == last_idx_r);
  assign out_v_o    = (state_r == send_s);
  assign out_fire   = out_v_o & out_ready_i;
  assign in_ready_o = ~reset_i & ((state_r == idle_s) | (out_fire & is_last));
  assign accept     = in_v_i & in_ready_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= idle_s;
      write_r    <= 1'b0;
      addr_r     <= '0;
      size_r     <= '0;
      data_r     <= '0;
      k_r        <= '0;
      last_idx_r <= '0;
      error_r    <= 1'b0;
    end else if (accept) begin
      state_r    <= send_s;
      write_r    <= in_write_i;
      addr_r     <= in_addr_i;
      size_r     <= size_c;
      data_r     <= in_data_i;
      k_r        <= '0;
      last_idx_r <= last_idx_in;
      if (oversize)
        error_r <= 1'b1;
    end else if (out_fire) begin
      if (is_last)
        state_r <= idle_s;
      else
        k_r <= k_r + 1'b1;
    end
  end

  logic [cnt_w_lp-1:0]      idx_cur;
  logic [cnt_w_lp-1:0]      idx_sum;
  logic [paddr_width_p-1:0] beat_addr;
  logic [fill_width_p-1:0]  beat_data;

  assign idx_cur = addr_r[off_w_lp +: cnt_w_lp];
  assign idx_sum = idx_cur + k_r;

  // Beat 0 keeps the requested (possibly unaligned) address; later beats wrap inside the transfer
  always_comb begin
    beat_addr = addr_r;
    if (k_r != '0) begin
      beat_addr[off_w_lp +: cnt_w_lp] = (idx_cur & ~last_idx_r) | (idx_sum & last_idx_r);
      beat_addr[off_w_lp-1:0]         = '0;
    end
  end

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < beats_lp; i++)
      if (k_r == cnt_w_lp'(i))
        beat_data = data_r[i*fill_width_p +: fill_width_p];
  end

  assign out_write_o = write_r;
  assign out_addr_o  = beat_addr;
  assign out_size_o  = size_r;
  assign out_data_o  = write_r ? beat_data : '0;
  assign out_first_o = out_v_o & (k_r == '0);
  assign out_last_o  = out_v_o & is_last;
  assign error_o     = error_r;

`ifdef BP_ME_FILL_SERIALIZER_PERF_EN
  logic [31:0] msg_count_r;
  logic [31:0] stall_count_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      msg_count_r   <= '0;
      stall_count_r <= '0;
    end else begin
      if (out_fire && is_last && (msg_count_r != 32'hFFFF_FFFF))
        msg_count_r <= msg_count_r + 32'd1;
      if (out_v_o && !out_ready_i && (stall_count_r != 32'hFFFF_FFFF))
        stall_count_r <= stall_count_r + 32'd1;
    end
  end

  assign msg_count_o   = msg_count_r;
  assign stall_count_o = stall_count_r;
`endif

endmodule

// File: tb/tb_bp_me_fill_serializer.sv
// tb/tb_bp_me_fill_serializer.sv - vector table plus scoreboard bench for bp_me_fill_serializer
// Connects the perf ports when BP_ME_FILL_SERIALIZER_PERF_EN is defined.
module tb_bp_me_fill_serializer;

  logic         clk;
  logic         reset_i;
  logic         in_v_i;
  logic         in_ready_o;
  logic         in_write_i;
  logic [33:0]  in_addr_i;
  logic [2:0]   in_size_i;
  logic [511:0] in_data_i;
  logic         out_v_o;
  logic         out_ready_i;
  logic         out_write_o;
  logic [33:0]  out_addr_o;
  logic [2:0]   out_size_o;
  logic [63:0]  out_data_o;
  logic         out_first_o;
  logic         out_last_o;
  logic         error_o;
`ifdef BP_ME_FILL_SERIALIZER_PERF_EN
  logic [31:0]  msg_count_o;
  logic [31:0]  stall_count_o;
`endif

  bp_me_fill_serializer dut (
    .clk_i(clk), .reset_i(reset_i),
    .in_v_i(in_v_i), .in_ready_o(in_ready_o), .in_write_i(in_write_i),
    .in_addr_i(in_addr_i), .in_size_i(in_size_i), .in_data_i(in_data_i),
    .out_v_o(out_v_o), .out_ready_i(out_ready_i), .out_write_o(out_write_o),
    .out_addr_o(out_addr_o), .out_size_o(out_size_o), .out_data_o(out_data_o),
    .out_first_o(out_first_o), .out_last_o(out_last_o),
`ifdef BP_ME_FILL_SERIALIZER_PERF_EN
    .msg_count_o(msg_count_o), .stall_count_o(stall_count_o),
`endif
    .error_o(error_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [33:0] addr;
    logic [63:0] data;
    logic        first;
    logic        last;
    logic        wr;
    logic [2:0]  size;
  } beat_t;

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [33:0] addr;
    int          beats;
  } vec_t;

  beat_t      exp_q[$];
  beat_t      held;
  int         errors = 0;
  int         checks = 0;
  int         beats_seen, stall_seen, run_len, max_run, phase, msgs;
  bit         rdy_mode, stalled_prev, last_accept;
  logic [7:0] addr_log [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push_expected(input logic wr, input logic [2:0] size,
                               input logic [33:0] addr, input logic [511:0] data);
    int sc, n, start;
    logic [33:0] base;
    beat_t b;
    sc    = (size > 3'd6) ? 6 : int'(size);
    n     = (wr && sc > 3) ? (1 << (sc - 3)) : 1;
    start = int'(addr[5:3]) % n;
    base  = addr & ~34'(n * 8 - 1);
    for (int k = 0; k < n; k++) begin
      b.addr  = (k == 0) ? addr : base + 34'(((start + k) % n) * 8);
      b.data  = wr ? data[k*64 +: 64] : 64'd0;
      b.first = (k == 0);
      b.last  = (k == n - 1);
      b.wr    = wr;
      b.size  = 3'(sc);
      exp_q.push_back(b);
    end
  endtask

  // Inputs settle, outputs are sampled 1ns later, then the clock edge commits
  task automatic tick();
    beat_t act, exp;
    if (rdy_mode) begin
      out_ready_i = (phase == 0);
      phase = (phase + 1) % 3;
    end else begin
      out_ready_i = 1'b1;
    end
    #1;
    last_accept = 1'b0;
    if (reset_i) begin
      stalled_prev = 1'b0;
      run_len = 0;
    end else begin
      act = {out_addr_o, out_data_o, out_first_o, out_last_o, out_write_o, out_size_o};
      if (stalled_prev)
        chk("hold", 128'(act), 128'(held));
      if (in_v_i && in_ready_o) begin
        last_accept = 1'b1;
        msgs++;
        push_expected(in_write_i, in_size_i, in_addr_i, in_data_i);
      end
      run_len = out_v_o ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      if (out_v_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat: got unexpected beat %h, required none", act);
        end else begin
          exp = exp_q.pop_front();
          chk("beat", 128'(act), 128'(exp));
        end
        if (beats_seen < 8) addr_log[beats_seen] = out_addr_o[7:0];
        beats_seen++;
      end
      stalled_prev = out_v_o && !out_ready_i;
      if (stalled_prev) begin
        held = act;
        stall_seen++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [2:0] size, input logic [33:0] addr,
                       input logic [511:0] data, input bit drop);
    in_v_i     = 1'b1;
    in_write_i = wr;
    in_size_i  = size;
    in_addr_i  = addr;
    in_data_i  = data;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (last_accept) break;
    end
    if (!last_accept) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance, required acceptance within 50 cycles");
    end
    if (drop) in_v_i = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      if (exp_q.size() == 0 && !out_v_o) break;
      tick();
    end
    chk("drain", {out_v_o, 32'(exp_q.size())}, 0);
  endtask

  vec_t         vec [8];
  logic [7:0]   exp_lo [8];
  logic [511:0] data;
  int           s0, b0;
`ifdef BP_ME_FILL_SERIALIZER_PERF_EN
  logic [31:0]  perf0;
`endif

  initial begin
    reset_i = 1'b1; in_v_i = 1'b0; in_write_i = 1'b0; in_addr_i = '0;
    in_size_i = '0; in_data_i = '0; out_ready_i = 1'b1;
    rdy_mode = 1'b0; stalled_prev = 1'b0; last_accept = 1'b0;
    beats_seen = 0; stall_seen = 0; run_len = 0; max_run = 0; phase = 0; msgs = 0;

    vec[0] = '{1'b1, 3'd6, 34'h0_8000_0010, 8};
    vec[1] = '{1'b0, 3'd6, 34'h0_8000_0040, 1};
    vec[2] = '{1'b1, 3'd2, 34'h0_8000_0004, 1};
    vec[3] = '{1'b1, 3'd4, 34'h0_8000_0038, 2};
    vec[4] = '{1'b1, 3'd5, 34'h2_0000_0069, 4};
    vec[5] = '{1'b0, 3'd0, 34'h3_FFFF_FFFF, 1};
    vec[6] = '{1'b1, 3'd3, 34'h0_0000_0007, 1};
    vec[7] = '{1'b1, 3'd6, 34'h0_8000_003F, 8};
    exp_lo = '{8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'h00, 8'h08};

    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", {out_v_o, in_ready_o, error_o, out_first_o, out_last_o, out_write_o}, 0);
    chk("reset_addr_data", {out_addr_o, out_data_o, out_size_o}, 0);
    @(negedge clk);
    reset_i = 1'b0;

    for (int v = 0; v < 8; v++) begin
      for (int w = 0; w < 16; w++) data[w*32 +: 32] = $urandom;
      beats_seen = 0;
      issue(vec[v].wr, vec[v].size, vec[v].addr, data, 1'b1);
      #1;
      chk("latency_first", {out_v_o, out_first_o}, 2'b11);
      drain();
      chk("beat_count", 128'(beats_seen), 128'(vec[v].beats));
      if (v == 0)
        for (int i = 0; i < 8; i++) chk("wrap_addr", addr_log[i], exp_lo[i]);
    end
    chk("error_clear", error_o, 0);

    // stalled delivery with out_ready pattern 1,0,0
    for (int w = 0; w < 16; w++) data[w*32 +: 32] = $urandom;
    rdy_mode = 1'b1; phase = 0; s0 = stall_seen; beats_seen = 0;
`ifdef BP_ME_FILL_SERIALIZER_PERF_EN
    perf0 = stall_count_o;
`endif
    issue(1'b1, 3'd6, 34'h0_8000_0028, data, 1'b1);
    drain();
    rdy_mode = 1'b0;
    chk("stall_beats", 128'(beats_seen), 128'd8);
`ifdef BP_ME_FILL_SERIALIZER_PERF_EN
    chk("stall_count", 128'(stall_count_o - perf0), 128'(stall_seen - s0));
    chk("msg_count", 128'(msg_count_o), 128'(msgs));
`endif

    // back-to-back: second command accepted on the first message's last beat
    max_run = 0; beats_seen = 0;
    for (int w = 0; w < 16; w++) data[w*32 +: 32] = $urandom;
    issue(1'b1, 3'd6, 34'h0_8000_0100, data, 1'b0);
    for (int w = 0; w < 16; w++) data[w*32 +: 32] = $urandom;
    issue(1'b1, 3'd6, 34'h0_8000_0218, data, 1'b1);
    drain();
    chk("b2b_run", 128'(max_run), 128'd16);
    chk("b2b_beats", 128'(beats_seen), 128'd16);

    // reset mid-message drops the remaining beats
    beats_seen = 0;
    for (int w = 0; w < 16; w++) data[w*32 +: 32] = $urandom;
    issue(1'b1, 3'd6, 34'h0_8000_0300, data, 1'b1);
    for (int t = 0; t < 50; t++) begin
      if (beats_seen >= 3) break;
      tick();
    end
    chk("beats_before_reset", 128'(beats_seen), 128'd3);
    reset_i = 1'b1;
    #1;
    chk("reset_drop", {out_v_o, out_first_o, out_last_o}, 0);
    exp_q.delete();
    repeat (2) tick();
    reset_i = 1'b0;
    #1;
    chk("ready_after_reset", {in_ready_o, error_o}, 2'b10);
    b0 = beats_seen;
    repeat (10) tick();
    chk("no_stale_beats", 128'(beats_seen - b0), 0);

    // oversize write clamps to block size and sets the sticky error
    beats_seen = 0;
    for (int w = 0; w < 16; w++) data[w*32 +: 32] = $urandom;
    issue(1'b1, 3'd7, 34'h0_8000_0080, data, 1'b1);
    drain();
    chk("oversize_beats", 128'(beats_seen), 128'd8);
    chk("error_set", error_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
